// File: rtl/branch_operand_stage.sv
// Decode-stage branch sequencer: latches a BEQ/BNE, resolves operand hazards
// (stall or MEM forward), feeds the external comparator and issues a fetch redirect.
module branch_operand_stage #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5,
    parameter int CNTW  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic             br_is_bne,
    input  logic [REGW-1:0]  br_rs,
    input  logic [REGW-1:0]  br_rt,
    input  logic [WIDTH-1:0] br_target,
    output logic [REGW-1:0]  ra1,
    output logic [REGW-1:0]  ra2,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    input  logic             ex_regwrite,
    input  logic [REGW-1:0]  ex_dest,
    input  logic             mem_regwrite,
    input  logic             mem_memtoreg,
    input  logic [REGW-1:0]  mem_dest,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             flush,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    input  logic             eq,
    output logic             stall,
    output logic             redirect_valid,
    output logic             redirect_taken,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [CNTW-1:0]  cnt_branches,
    output logic [CNTW-1:0]  cnt_taken,
    output logic [CNTW-1:0]  cnt_stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CMP  = 2'd2
    } state_t;

    state_t           state_q;
    logic [REGW-1:0]  rs_q;
    logic [REGW-1:0]  rt_q;
    logic             is_bne_q;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] cmp_a_q;
    logic [WIDTH-1:0] cmp_b_q;
    logic             redirect_valid_q;
    logic             redirect_taken_q;
    logic [WIDTH-1:0] redirect_pc_q;
    logic [CNTW-1:0]  cnt_branches_q;
    logic [CNTW-1:0]  cnt_taken_q;
    logic [CNTW-1:0]  cnt_stall_q;

    logic             haz_a;
    logic             haz_b;
    logic             fwd_a;
    logic             fwd_b;
    logic [WIDTH-1:0] cmp_a_d;
    logic [WIDTH-1:0] cmp_b_d;
    logic             taken_d;

    // Register 0 is hard-wired zero: never a hazard and never forwarded.
    assign haz_a = (rs_q != '0) &&
                   ((ex_regwrite && (ex_dest == rs_q)) ||
                    (mem_regwrite && mem_memtoreg && (mem_dest == rs_q)));
    assign haz_b = (rt_q != '0) &&
                   ((ex_regwrite && (ex_dest == rt_q)) ||
                    (mem_regwrite && mem_memtoreg && (mem_dest == rt_q)));

    assign fwd_a = (rs_q != '0) && mem_regwrite && !mem_memtoreg && (mem_dest == rs_q);
    assign fwd_b = (rt_q != '0) && mem_regwrite && !mem_memtoreg && (mem_dest == rt_q);

    assign cmp_a_d = fwd_a ? mem_result : rd1;
    assign cmp_b_d = fwd_b ? mem_result : rd2;
    assign taken_d = is_bne_q ? !eq : eq;

    assign br_ready = (state_q == S_IDLE) && !flush;
    assign stall    = (state_q == S_WAIT) && (haz_a || haz_b);

    assign ra1            = rs_q;
    assign ra2            = rt_q;
    assign cmp_a          = cmp_a_q;
    assign cmp_b          = cmp_b_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_taken = redirect_taken_q;
    assign redirect_pc    = redirect_pc_q;
    assign cnt_branches   = cnt_branches_q;
    assign cnt_taken      = cnt_taken_q;
    assign cnt_stall      = cnt_stall_q;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the early default on redirect_valid_q makes it a pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            rs_q             <= '0;
            rt_q             <= '0;
            is_bne_q         <= 1'b0;
            target_q         <= '0;
            cmp_a_q          <= '0;
            cmp_b_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_taken_q <= 1'b0;
            redirect_pc_q    <= '0;
            cnt_branches_q   <= '0;
            cnt_taken_q      <= '0;
            cnt_stall_q      <= '0;
        end else begin
            redirect_valid_q <= 1'b0;
            if (stall) begin
                cnt_stall_q <= cnt_stall_q + CNTW'(1);
            end

            // Flush wins over everything; only the stall counter above still moves.
            if (flush) begin
                state_q <= S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (br_valid) begin
                            rs_q     <= br_rs;
                            rt_q     <= br_rt;
                            is_bne_q <= br_is_bne;
                            target_q <= br_target;
                            state_q  <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (!(haz_a || haz_b)) begin
                            cmp_a_q <= cmp_a_d;
                            cmp_b_q <= cmp_b_d;
                            state_q <= S_CMP;
                        end
                    end
                    S_CMP: begin
                        redirect_valid_q <= 1'b1;
                        redirect_taken_q <= taken_d;
                        redirect_pc_q    <= target_q;
                        cnt_branches_q   <= cnt_branches_q + CNTW'(1);
                        cnt_taken_q      <= cnt_taken_q + CNTW'(taken_d);
                        state_q          <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
